cond_branch_unit: RTL

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

---
 rtl/cond_branch_unit_pkg.sv | 36 +++
 rtl/cond_eval.sv | 44 ++++
 rtl/cond_branch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cond_branch_unit_pkg.sv
// Shared types for the conditional branch unit.
//   cond_e  : 4-bit branch condition encoding
//   state_e : resolution FSM states
//   Flag*   : bit positions of {N,Z,C,V} inside a 4-bit flag word
package cond_branch_unit_pkg;

  typedef enum logic [3:0] {
    CondNever  = 4'h0,
    CondAlways = 4'h1,
    CondEq     = 4'h2,  // Z
    CondNe     = 4'h3,  // ~Z
    CondLt     = 4'h4,  // N^V
    CondGe     = 4'h5,  // ~(N^V)
    CondLe     = 4'h6,  // (N^V) | Z
    CondGt     = 4'h7,  // ~(N^V) & ~Z
    CondMi     = 4'h8,  // N
    CondPl     = 4'h9,  // ~N
    CondVs     = 4'hA,  // V
    CondVc     = 4'hB,  // ~V
    CondCs     = 4'hC,  // C
    CondCc     = 4'hD,  // ~C
    CondCsOrZ  = 4'hE,  // C | Z
    CondNcNz   = 4'hF   // ~(C | Z)
  } cond_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } state_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator.
//   cond  : condition code
//   flags : {N,Z,C,V} to test
//   taken : 1 when the condition holds
module cond_eval
  import cond_branch_unit_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v, lt;

  assign n  = flags[FlagN];
  assign z  = flags[FlagZ];
  assign c  = flags[FlagC];
  assign v  = flags[FlagV];
  assign lt = n ^ v;

  always_comb begin
    taken = 1'b0;
    case (cond)
      CondNever:  taken = 1'b0;
      CondAlways: taken = 1'b1;
      CondEq:     taken = z;
      CondNe:     taken = ~z;
      CondLt:     taken = lt;
      CondGe:     taken = ~lt;
      CondLe:     taken = lt | z;
      CondGt:     taken = ~lt & ~z;
      CondMi:     taken = n;
      CondPl:     taken = ~n;
      CondVs:     taken = v;
      CondVc:     taken = ~v;
      CondCs:     taken = c;
      CondCc:     taken = ~c;
      CondCsOrZ:  taken = c | z;
      CondNcNz:   taken = ~(c | z);
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution unit.
// Holds the architectural flags, resolves one branch per accept, reports the
// decision one cycle later and squashes younger stages for FLUSH_CYCLES cycles
// after a taken branch.
//   clk, rst_n          : clock, async active-low reset
//   stall               : freezes all state
//   cc_we, cc_in        : flag write {N,Z,C,V}
//   br_valid/br_ready   : branch request handshake, br_cond, br_target payload
//   res_valid/res_taken/res_target : registered resolution result
//   flush               : squash younger stages
//   cc_q                : architectural flags
//   taken_cnt           : saturating taken-branch count
module cond_branch_unit
  import cond_branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              cc_we,
  input  logic [3:0]        cc_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              flush,
  output logic [3:0]        cc_q,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q;
  logic               res_valid_q, res_taken_q;
  logic [ADDR_W-1:0]  res_target_q;
  logic [3:0]         cc_eff;
  logic               br_taken;
  logic               accept;

  // Forwarding lets a flag-setting instruction and a dependent branch resolve
  // in the same cycle.
  assign cc_eff = ((FWD_EN == 1) && cc_we) ? cc_in : cc_q;

  cond_eval u_cond_eval (
    .cond  (cond_e'(br_cond)),
    .flags (cc_eff),
    .taken (br_taken)
  );

  assign br_ready = (state_q == StIdle);
  assign accept   = br_valid & br_ready & ~stall;
  assign flush    = (state_q == StFlush);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && br_taken) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end
      end
      StFlush: begin
        if (!stall) begin
          if (cnt_q == 4'd1) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flags are written regardless of FSM state; only stall blocks them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= 4'b0000;
    end else if (cc_we && !stall) begin
      cc_q <= cc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
    end else if (accept && br_taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  // res_valid is a pulse: it follows accept, which is already gated by stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q  <= br_taken;
        res_target_q <= br_target;
      end
    end
  end

  assign res_valid  = res_valid_q;
  assign res_taken  = res_taken_q;
  assign res_target = res_target_q;
  assign taken_cnt  = taken_cnt_q;

endmodule
